// File: rtl/mem_copy_engine_pkg.sv
// Shared types and constants for the memory copy/fill engine.
package mem_copy_engine_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_WRITE  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Byte-wide single-port data memory bus: the engine is the master, the memory the slave.
interface mem_copy_engine_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] MemAddress;
    logic [DATA_W-1:0] MemWriteData;
    logic              MemWrite;
    logic              MemRead;
    logic [DATA_W-1:0] MemReadData;

    modport master (
        output MemAddress, MemWriteData, MemWrite, MemRead,
        input  MemReadData
    );

    modport slave (
        input  MemAddress, MemWriteData, MemWrite, MemRead,
        output MemReadData
    );
endinterface

// File: rtl/mem_copy_ctr.sv
// Loadable wrap-around register with increment/decrement; load wins over inc, inc over dec.
// Latency: one cycle. No backpressure.
// Arithmetic is modulo 2^W.
module mem_copy_ctr #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] value
);
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (inc) begin
            q <= q + ONE;
        end else if (dec) begin
            q <= q - ONE;
        end
    end

    assign value = q;
endmodule

// File: rtl/mem_copy_engine.sv
// Copy (read/write alternating) or fill (write every cycle) a block of the data memory on Start.
// Latency: copy 2N+1, fill N+1, zero-length 1 cycle from the accepting edge to Done.
// Start is only honoured in IDLE; requests while Busy are dropped, never queued.
module mem_copy_engine
    import mem_copy_engine_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              Mode,
    input  logic [ADDR_W-1:0] SrcAddr,
    input  logic [ADDR_W-1:0] DstAddr,
    input  logic [ADDR_W:0]   Length,
    input  logic [DATA_W-1:0] FillValue,
    output logic              Busy,
    output logic              Done,
    mem_copy_engine_if.master mem
);
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t state_q, state_d;

    logic              accept;
    logic              mode_q;
    logic [DATA_W-1:0] fill_q;
    logic [DATA_W-1:0] hold_q;
    logic [ADDR_W-1:0] last_addr_q;
    logic [DATA_W-1:0] last_wdata_q;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [ADDR_W:0]   remaining;

    assign accept = (state_q == ST_IDLE) && Start;

    mem_copy_ctr #(.W(ADDR_W)) u_src (
        .Clk(Clk), .Reset_n(Reset_n), .load(accept), .load_val(SrcAddr),
        .inc(state_q == ST_READ), .dec(1'b0), .value(src_ptr)
    );

    mem_copy_ctr #(.W(ADDR_W)) u_dst (
        .Clk(Clk), .Reset_n(Reset_n), .load(accept), .load_val(DstAddr),
        .inc(state_q == ST_WRITE), .dec(1'b0), .value(dst_ptr)
    );

    mem_copy_ctr #(.W(ADDR_W + 1)) u_cnt (
        .Clk(Clk), .Reset_n(Reset_n), .load(accept), .load_val(Length),
        .inc(1'b0), .dec(state_q == ST_WRITE), .value(remaining)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_COPY;
            fill_q       <= '0;
            hold_q       <= '0;
            last_addr_q  <= '0;
            last_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                mode_q <= Mode;
                fill_q <= FillValue;
            end
            if (state_q == ST_READ) begin
                hold_q <= mem.MemReadData;
            end
            // Remembered so the bus holds steady in IDLE/FINISH instead of snapping to a pointer.
            if (state_q == ST_READ || state_q == ST_WRITE) begin
                last_addr_q <= mem.MemAddress;
            end
            if (state_q == ST_WRITE) begin
                last_wdata_q <= mem.MemWriteData;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    if (Length == '0)            state_d = ST_FINISH;
                    else if (Mode == MODE_FILL)  state_d = ST_WRITE;
                    else                         state_d = ST_READ;
                end
            end
            ST_READ:  state_d = ST_WRITE;
            ST_WRITE: begin
                if (remaining == CNT_ONE)        state_d = ST_FINISH;
                else if (mode_q == MODE_FILL)    state_d = ST_WRITE;
                else                             state_d = ST_READ;
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem.MemRead      = 1'b0;
        mem.MemWrite     = 1'b0;
        mem.MemAddress   = last_addr_q;
        mem.MemWriteData = last_wdata_q;
        case (state_q)
            ST_READ: begin
                mem.MemRead    = 1'b1;
                mem.MemAddress = src_ptr;
            end
            ST_WRITE: begin
                mem.MemWrite     = 1'b1;
                mem.MemAddress   = dst_ptr;
                mem.MemWriteData = (mode_q == MODE_FILL) ? fill_q : hold_q;
            end
            default: ;
        endcase
    end

    assign Busy = (state_q != ST_IDLE);
    assign Done = (state_q == ST_FINISH);
endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine: behavioural byte memory on the bus, hand-computed expectations.
module tb_mem_copy_engine;
    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       Start;
    logic       Mode;
    logic [7:0] SrcAddr, DstAddr, FillValue;
    logic [8:0] Length;
    logic       Busy, Done;

    always #5 Clk = ~Clk;

    mem_copy_engine_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    mem_copy_engine #(.ADDR_W(8), .DATA_W(8)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Mode(Mode),
        .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Length(Length), .FillValue(FillValue),
        .Busy(Busy), .Done(Done), .mem(bus)
    );

    // Background memory: every byte starts as the complement of its address.
    logic [7:0] mem [256];
    logic       pl_en;
    logic [7:0] pl_addr, pl_data;

    always @(posedge Clk) begin
        if (bus.MemWrite) mem[bus.MemAddress] <= bus.MemWriteData;
        else if (pl_en)   mem[pl_addr] <= pl_data;
    end
    assign bus.MemReadData = mem[bus.MemAddress];

    int nvec = 0;
    int nmis = 0;
    logic [7:0] wr_q [$];
    int done_cyc, n_wr, n_rd, n_both, n_busy_lo, extra, cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge Clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge Clk);
        #1 pl_en = 1'b0;
    endtask

    // Issues one request and watches the bus until Done; cycle 1 is the accepting edge.
    task automatic run_op(input logic md, input logic [7:0] src, input logic [7:0] dst,
                          input logic [8:0] len, input logic [7:0] fill, input int restart_cyc);
        @(negedge Clk);
        Mode = md; SrcAddr = src; DstAddr = dst; Length = len; FillValue = fill; Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        done_cyc = -1; n_wr = 0; n_rd = 0; n_both = 0; n_busy_lo = 0;
        wr_q.delete();
        for (int cyc = 1; cyc <= 600 && done_cyc < 0; cyc++) begin
            @(negedge Clk);
            Start = 1'b0;
            if (Done) done_cyc = cyc;
            if (bus.MemWrite) begin
                n_wr++;
                wr_q.push_back(bus.MemAddress);
            end
            if (bus.MemRead) n_rd++;
            if (bus.MemWrite && bus.MemRead) n_both++;
            if (!Busy) n_busy_lo++;
            if (cyc == restart_cyc) begin
                Mode = 1'b1; DstAddr = 8'h90; Length = 9'd1; FillValue = 8'h77; Start = 1'b1;
            end
        end
        Start = 1'b0;
    endtask

    initial begin
        Reset_n = 1'b0; Start = 1'b0; Mode = 1'b0; SrcAddr = '0; DstAddr = '0;
        Length = '0; FillValue = '0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        #12;
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_wr", bus.MemWrite, 0);
        chk("rst_rd", bus.MemRead, 0);
        chk("rst_addr", bus.MemAddress, 0);
        chk("rst_wdata", bus.MemWriteData, 0);
        @(negedge Clk) Reset_n = 1'b1;

        for (int i = 0; i < 256; i++) poke(i[7:0], ~i[7:0]);

        // Fill 4 bytes at 0x10 with A5
        run_op(1'b1, 8'h00, 8'h10, 9'd4, 8'hA5, 0);
        chk("fill_done_cyc", done_cyc, 5);
        chk("fill_nwr", n_wr, 4);
        chk("fill_nrd", n_rd, 0);
        chk("fill_busy", n_busy_lo, 0);
        for (int i = 0; i < 4; i++) begin
            chk("fill_wr_addr", (i < wr_q.size()) ? wr_q[i] : 8'hXX, 8'h10 + i[7:0]);
            chk("fill_mem", mem[8'h10 + i[7:0]], 8'hA5);
        end
        chk("fill_mem_14", mem[8'h14], 8'hEB);
        chk("fill_hold_addr", bus.MemAddress, 8'h13);
        @(negedge Clk);
        chk("fill_idle_busy", Busy, 0);
        chk("fill_idle_done", Done, 0);

        // Copy 3 bytes 0x00 -> 0x80
        poke(8'h00, 8'h11); poke(8'h01, 8'h22); poke(8'h02, 8'h33);
        run_op(1'b0, 8'h00, 8'h80, 9'd3, 8'h00, 0);
        chk("copy_done_cyc", done_cyc, 7);
        chk("copy_nwr", n_wr, 3);
        chk("copy_nrd", n_rd, 3);
        chk("copy_both", n_both, 0);
        chk("copy_mem_80", mem[8'h80], 8'h11);
        chk("copy_mem_81", mem[8'h81], 8'h22);
        chk("copy_mem_82", mem[8'h82], 8'h33);
        chk("copy_mem_83", mem[8'h83], 8'h7C);

        // Fill wrapping past the top of memory
        run_op(1'b1, 8'h00, 8'hFE, 9'd3, 8'h5C, 0);
        chk("wrap_done_cyc", done_cyc, 4);
        chk("wrap_wr_addr2", (wr_q.size() > 2) ? wr_q[2] : 8'hXX, 8'h00);
        chk("wrap_mem_fe", mem[8'hFE], 8'h5C);
        chk("wrap_mem_ff", mem[8'hFF], 8'h5C);
        chk("wrap_mem_00", mem[8'h00], 8'h5C);
        chk("wrap_mem_01", mem[8'h01], 8'h22);

        // Zero length: Done on the next cycle, no bus activity
        run_op(1'b0, 8'h00, 8'h40, 9'd0, 8'h00, 0);
        chk("len0_done_cyc", done_cyc, 1);
        chk("len0_nwr", n_wr, 0);
        chk("len0_nrd", n_rd, 0);

        // 4-byte copy 0x00 -> 0x40 with a second Start raised mid-transfer
        poke(8'h00, 8'h11); poke(8'h03, 8'h44);
        run_op(1'b0, 8'h00, 8'h40, 9'd4, 8'h00, 2);
        chk("rstrt_done_cyc", done_cyc, 9);
        extra = 0;
        repeat (12) begin
            @(negedge Clk);
            if (Done) extra++;
        end
        chk("rstrt_extra_done", extra, 0);
        chk("rstrt_mem_40", mem[8'h40], 8'h11);
        chk("rstrt_mem_43", mem[8'h43], 8'h44);
        chk("rstrt_mem_90", mem[8'h90], 8'h6F);

        // Overlapping ascending copy propagates the first byte
        poke(8'h20, 8'h01); poke(8'h21, 8'h02); poke(8'h22, 8'h03);
        run_op(1'b0, 8'h20, 8'h21, 9'd2, 8'h00, 0);
        chk("ovl_mem_21", mem[8'h21], 8'h01);
        chk("ovl_mem_22", mem[8'h22], 8'h01);

        // Reset during the third write of an 8-byte fill
        @(negedge Clk);
        Mode = 1'b1; DstAddr = 8'h60; Length = 9'd8; FillValue = 8'hC3; Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("mid_pre_wr", bus.MemWrite, 1);
        chk("mid_pre_addr", bus.MemAddress, 8'h62);
        Reset_n = 1'b0;
        #1;
        chk("mid_rst_wr", bus.MemWrite, 0);
        chk("mid_rst_addr", bus.MemAddress, 0);
        chk("mid_rst_busy", Busy, 0);
        extra = 0;
        repeat (3) begin
            @(negedge Clk);
            if (Done) extra++;
        end
        Reset_n = 1'b1;
        repeat (3) begin
            @(negedge Clk);
            if (Done) extra++;
        end
        chk("mid_no_done", extra, 0);
        cnt = 0;
        for (int i = 0; i < 8; i++) if (mem[8'h60 + i[7:0]] == 8'hC3) cnt++;
        chk("mid_bytes_2or3", (cnt == 2 || cnt == 3), 1);
        chk("mid_mem_60", mem[8'h60], 8'hC3);
        chk("mid_mem_64", mem[8'h64], 8'h9B);

        run_op(1'b1, 8'h00, 8'h70, 9'd2, 8'h3A, 0);
        chk("post_done_cyc", done_cyc, 3);
        chk("post_mem_70", mem[8'h70], 8'h3A);
        chk("post_mem_71", mem[8'h71], 8'h3A);
        chk("post_mem_72", mem[8'h72], 8'h8D);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
